// File: rtl/vvmac_seq_pkg.sv
// -----------------------------------------------------------------------------
// vvmac_seq_pkg
// Shared definitions for the serial vector-vector MAC stage and the tanh
// activation stage it feeds: default widths, Q-format fraction bits,
// saturation bounds of the Q3.14 result and the control FSM encoding.
// -----------------------------------------------------------------------------
package vvmac_seq_pkg;

  // Default widths, shared with the activation stage.
  localparam int DEF_IN_W    = 16;  // activation, Q9.7
  localparam int DEF_W_W     = 16;  // weight, Q2.14
  localparam int DEF_OUT_W   = 17;  // pre-activation, Q3.14
  localparam int DEF_ACC_W   = 40;  // accumulator, Q.21
  localparam int DEF_MAX_LEN = 256;
  localparam int DEF_CNT_W   = 9;

  // Fraction bits of each Q format.
  localparam int IN_FRAC   = 7;
  localparam int W_FRAC    = 14;
  localparam int OUT_FRAC  = 14;
  localparam int ACC_FRAC  = IN_FRAC + W_FRAC;   // 21
  localparam int ACC_SHIFT = ACC_FRAC - OUT_FRAC; // 7: Q.21 -> Q.14

  // Saturation bounds of the Q3.14 result (+3.99994 / -4.0).
  localparam logic [DEF_OUT_W-1:0] SAT_POS = 17'h0FFFF;
  localparam logic [DEF_OUT_W-1:0] SAT_NEG = 17'h10000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/vvmac_seq_sat_shift.sv
// -----------------------------------------------------------------------------
// vvmac_seq_sat_shift
// Combinational narrowing of a wide signed accumulator: arithmetic shift
// right by SHIFT (floor, no rounding) followed by saturation to OUT_W bits.
// Reusable for any layer output that narrows an accumulator.
//   acc  : signed accumulator, IN_W bits
//   data : shifted and saturated result, OUT_W bits
//   sat  : 1 when the shifted value did not fit and was clamped
// -----------------------------------------------------------------------------
module vvmac_seq_sat_shift
  import vvmac_seq_pkg::*;
#(
  parameter int               IN_W   = DEF_ACC_W,
  parameter int               OUT_W  = DEF_OUT_W,
  parameter int               SHIFT  = ACC_SHIFT,
  parameter logic [OUT_W-1:0] SAT_HI = {1'b0, {(OUT_W-1){1'b1}}},
  parameter logic [OUT_W-1:0] SAT_LO = {1'b1, {(OUT_W-1){1'b0}}}
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic        [OUT_W-1:0] data,
  output logic                    sat
);

  logic signed [IN_W-1:0]      shifted;
  logic        [IN_W-OUT_W:0]  top_bits;
  logic                        fits;

  // NOTE: every variable assigned in always_comb gets a default on entry so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    shifted  = acc >>> SHIFT;
    // The value fits in OUT_W bits when all bits from the OUT_W sign position
    // upward are copies of the sign.
    top_bits = shifted[IN_W-1:OUT_W-1];
    fits     = (&top_bits) | ~(|top_bits);
    data     = shifted[OUT_W-1:0];
    sat      = 1'b0;
    if (!fits) begin
      sat  = 1'b1;
      data = shifted[IN_W-1] ? SAT_LO : SAT_HI;
    end
  end

endmodule

// File: rtl/vvmac_seq.sv
// -----------------------------------------------------------------------------
// vvmac_seq
// Serial vector-vector multiply-accumulate for one neuron lane. Streams
// (activation, weight) pairs, adds a per-vector bias and delivers one
// saturated Q3.14 pre-activation per vector to the activation stage.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : pair valid            in_ready : stage accepts a pair
//   in_x         : activation, Q9.7      in_w     : weight, Q2.14
//   in_last      : final pair of vector
//   bias         : Q3.14, taken with the first accepted pair of a vector
//   out_valid    : result valid          out_ready: downstream accepts
//   out_data     : saturated Q3.14 sum   out_sat  : result was clamped
//   out_len_err  : vector was forced closed at MAX_LEN without in_last
//
// Pipeline (last pair accepted in cycle t): product registered t+1,
// accumulator updated t+2, result presented t+3.
// -----------------------------------------------------------------------------
module vvmac_seq
  import vvmac_seq_pkg::*;
#(
  parameter int VVMAC_IN_W  = DEF_IN_W,
  parameter int W_W         = DEF_W_W,
  parameter int VVMAC_OUT_W = DEF_OUT_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int MAX_LEN     = DEF_MAX_LEN,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VVMAC_IN_W-1:0]  in_x,
  input  logic [W_W-1:0]         in_w,
  input  logic                   in_last,
  input  logic [VVMAC_OUT_W-1:0] bias,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VVMAC_OUT_W-1:0] out_data,
  output logic                   out_sat,
  output logic                   out_len_err
);

  localparam int PROD_W = VVMAC_IN_W + W_W;  // Q11.21

  state_e state;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             at_max;
  logic             close_vec;
  logic             len_err_q;

  // Stage 1: product plus the flags that travel with it.
  logic                     prod_vld;
  logic                     prod_first;
  logic                     prod_last;
  logic signed [PROD_W-1:0] prod_q;
  logic [VVMAC_OUT_W-1:0]   bias_q;

  // Stage 2: accumulator; acc_done marks that it holds a finished vector.
  logic signed [ACC_W-1:0]  acc_q;
  logic                     acc_done;

  logic [VVMAC_OUT_W-1:0]   sat_data;
  logic                     sat_flag;

  assign accept    = in_valid & in_ready;
  assign cnt_inc   = cnt + CNT_W'(1);
  assign at_max    = (cnt_inc == CNT_W'(MAX_LEN));
  assign close_vec = accept & (in_last | at_max);

  // Pipeline valids are reset so a mid-vector reset discards everything
  // in flight; the data registers beside them need no reset.
  // NOTE: sequential state is written with non-blocking assignments so all
  // registers update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_vld <= 1'b0;
      acc_done <= 1'b0;
    end else begin
      prod_vld <= accept;
      acc_done <= prod_vld & prod_last;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      prod_q     <= PROD_W'($signed(in_x)) * PROD_W'($signed(in_w));
      prod_first <= (cnt == '0);
      prod_last  <= in_last | at_max;
      bias_q     <= bias;
    end
    if (prod_vld) begin
      // Bias is Q3.14; shifting by 7 aligns it to the Q.21 accumulator.
      if (prod_first)
        acc_q <= (ACC_W'($signed(bias_q)) <<< ACC_SHIFT) + ACC_W'(prod_q);
      else
        acc_q <= acc_q + ACC_W'(prod_q);
    end
  end

  vvmac_seq_sat_shift #(
    .IN_W   (ACC_W),
    .OUT_W  (VVMAC_OUT_W),
    .SHIFT  (ACC_SHIFT),
    .SAT_HI (VVMAC_OUT_W'(SAT_POS)),
    .SAT_LO (VVMAC_OUT_W'(SAT_NEG))
  ) u_sat_shift (
    .acc  (acc_q),
    .data (sat_data),
    .sat  (sat_flag)
  );

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sat     <= 1'b0;
      out_len_err <= 1'b0;
      cnt         <= '0;
      len_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            cnt <= cnt_inc;
            if (close_vec) begin
              state     <= ST_DRAIN;
              in_ready  <= 1'b0;
              // Only a vector closed by the length limit is an error; a
              // vector of exactly MAX_LEN ending in in_last is legal.
              len_err_q <= ~in_last;
            end
          end
        end
        ST_DRAIN: begin
          if (acc_done) begin
            state       <= ST_HOLD;
            out_valid   <= 1'b1;
            out_data    <= sat_data;
            out_sat     <= sat_flag;
            out_len_err <= len_err_q;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state       <= ST_RUN;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            cnt         <= '0;
            len_err_q   <= 1'b0;
            out_len_err <= 1'b0;
          end
        end
        default: begin
          state    <= ST_RUN;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vvmac_seq.sv
// -----------------------------------------------------------------------------
// tb_vvmac_seq
// Directed vectors with hand-computed Q3.14 results for vvmac_seq, built
// with MAX_LEN=4 so the length limit is reachable in a few pairs.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_vvmac_seq;

  localparam int TB_MAX_LEN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_w;
  logic        in_last;
  logic [16:0] bias;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic        out_sat;
  logic        out_len_err;

  int checks = 0;
  int errors = 0;

  vvmac_seq #(.MAX_LEN(TB_MAX_LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_w        (in_w),
    .in_last     (in_last),
    .bias        (bias),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sat     (out_sat),
    .out_len_err (out_len_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Offer one pair and return on the falling edge after it was taken.
  task automatic send(input logic [15:0] x, input logic [15:0] w,
                      input logic last, input logic [16:0] b);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_w     = w;
    in_last  = last;
    bias     = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Compare the presented result, accept it, and confirm the input side reopens.
  task automatic take_result(input string tag, input logic [16:0] exp_data,
                             input logic exp_sat, input logic exp_len);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"},  out_data, exp_data);
    check({tag, "_sat"},   out_sat, exp_sat);
    check({tag, "_len"},   out_len_err, exp_len);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_reopen"}, in_ready, 1);
    check({tag, "_drop"},   out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_x      = '0;
    in_w      = '0;
    bias      = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data, 17'h00000);
    check("rst_out_sat",   out_sat, 0);
    check("rst_len_err",   out_len_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single pair 1.0 * 0.5; result 3 cycles after acceptance, i.e. two
    // falling edges after the one on which send() returns.
    send(16'h0080, 16'h2000, 1'b1, 17'h00000);
    check("single_busy", in_ready, 0);
    wait_valid(lat);
    check("single_latency", lat, 2);
    take_result("single", 17'h02000, 1'b0, 1'b0);

    // Sign and floor behaviour.
    send(16'hFF80, 16'h4000, 1'b1, 17'h00000);
    wait_valid(lat);
    take_result("neg_one", 17'h1C000, 1'b0, 1'b0);

    send(16'hFFFF, 16'h0001, 1'b1, 17'h00000);
    wait_valid(lat);
    take_result("floor_neg", 17'h1FFFF, 1'b0, 1'b0);

    send(16'h0001, 16'h0001, 1'b1, 17'h00000);
    wait_valid(lat);
    take_result("floor_pos", 17'h00000, 1'b0, 1'b0);

    // Saturation; 4 pairs closed by in_last at exactly MAX_LEN is no error.
    for (int i = 0; i < 4; i++) send(16'h7FFF, 16'h7FFF, (i == 3), 17'h00000);
    wait_valid(lat);
    take_result("sat_pos", 17'h0FFFF, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) send(16'h7FFF, 16'h8000, (i == 3), 17'h00000);
    wait_valid(lat);
    take_result("sat_neg", 17'h10000, 1'b1, 1'b0);

    // Bias 1.0 + 3 * 1.0 = 4.0 saturates positive. Bias changes after the
    // first pair and a stray in_last without in_valid must both be ignored.
    send(16'h0080, 16'h4000, 1'b0, 17'h04000);
    in_last = 1'b1;
    @(negedge clk);
    in_last = 1'b0;
    send(16'h0080, 16'h4000, 1'b0, 17'h10000);
    send(16'h0080, 16'h4000, 1'b1, 17'h10000);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data",  out_data, 17'h0FFFF);
      check("bp_ready", in_ready, 0);
      @(negedge clk);
    end
    take_result("bias_bp", 17'h0FFFF, 1'b1, 1'b0);

    // Length limit: 4 pairs without in_last are forced closed (4.0 clamps),
    // the next 2 form a fresh vector giving 2.0.
    for (int i = 0; i < 4; i++) send(16'h0080, 16'h4000, 1'b0, 17'h00000);
    wait_valid(lat);
    take_result("len_forced", 17'h0FFFF, 1'b1, 1'b1);
    send(16'h0080, 16'h4000, 1'b0, 17'h00000);
    send(16'h0080, 16'h4000, 1'b1, 17'h00000);
    wait_valid(lat);
    take_result("len_next", 17'h08000, 1'b0, 1'b0);

    // Reset mid-vector discards the partial sum.
    send(16'h7FFF, 16'h7FFF, 1'b0, 17'h04000);
    send(16'h7FFF, 16'h7FFF, 1'b0, 17'h04000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_ready", in_ready, 1);
    send(16'h0080, 16'h2000, 1'b1, 17'h00000);
    wait_valid(lat);
    take_result("after_rst", 17'h02000, 1'b0, 1'b0);

    // Reset while a result is held drops it.
    send(16'h0080, 16'h2000, 1'b1, 17'h00000);
    wait_valid(lat);
    check("hold_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_hold_valid", out_valid, 0);
    check("rst_hold_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
